packet_reassembler: RTL and testbench

Collects decoded flits arriving from the link receiver into a small pool of `packet_types::packet_element_t` slots, one per in-flight packet, keyed by `packet_id`. Slots whose packets finish are handed downstream one at a time over a valid/ready port to the routing/application stage. Slots stalled longer than `EXPIRE_TIME` cycles between flits are discarded.

---
 rtl/packet_reassembler_pkg.sv | 32 +++
 rtl/packet_reassembler_lowest_index_finder.sv | 24 ++
 rtl/packet_reassembler.sv | 181 ++++++++++++++++++
 tb/tb_packet_reassembler.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_reassembler_pkg.sv
// Shared types for the packet reassembler: flit/packet payloads, slot element and drop reasons.
package packet_reassembler_pkg;

  localparam int unsigned FLIT_W            = 16;
  localparam int unsigned PACKET_ID_W       = 8;
  localparam int unsigned MAX_NUM_OF_FLIT   = 8;
  localparam int unsigned EXPIRE_TIME       = 100;
  localparam int unsigned DEFAULT_NUM_SLOTS = 4;
  localparam int unsigned STAT_W            = 16;
  localparam int unsigned TAIL_W            = $clog2(MAX_NUM_OF_FLIT);
  localparam int unsigned TIMER_W           = $clog2(EXPIRE_TIME);

  typedef logic [FLIT_W-1:0]      flit_t;
  typedef logic [PACKET_ID_W-1:0] packet_id_t;

  // One reassembly slot; buffer[0] holds the head flit, tail_index points at the last written flit.
  typedef struct packed {
    packet_id_t                        packet_id;
    flit_t [MAX_NUM_OF_FLIT-1:0]       buffer;
    logic  [TAIL_W-1:0]                tail_index;
    logic  [TIMER_W-1:0]               timer;
    logic                              is_complete;
  } packet_element_t;

  typedef enum logic [1:0] {
    DROP_NONE     = 2'd0,
    DROP_NO_SLOT  = 2'd1,
    DROP_NO_MATCH = 2'd2,
    DROP_OVERFLOW = 2'd3
  } drop_reason_t;

endpackage

// File: rtl/packet_reassembler_lowest_index_finder.sv
// Priority encoder: index of the lowest set request bit plus a found flag.
module lowest_index_finder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0]         req,
  output logic [$clog2(WIDTH)-1:0] idx_c,
  output logic                     found_c
);

  localparam int unsigned IDX_W = $clog2(WIDTH);

  // Scan from the top so the last hit written is the lowest index.
  always_comb begin
    found_c = 1'b0;
    idx_c   = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (req[i]) begin
        found_c = 1'b1;
        idx_c   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/packet_reassembler.sv
// Reassembles flits into per-packet slots keyed by packet_id, delivers complete packets over
// valid/ready, and drops or expires stray traffic.
// Optional feature macro PACKET_REASSEMBLER_STATS_EN adds saturating drop/expire counters.
module packet_reassembler
  import packet_reassembler_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = DEFAULT_NUM_SLOTS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  flit_t           in_flit,
  input  packet_id_t      in_packet_id,
  input  logic            in_is_head,
  input  logic            in_is_tail,
  output logic            out_valid,
  input  logic            out_ready,
  output packet_element_t out_packet,
  output logic            drop_pulse,
  output drop_reason_t    drop_reason,
  output logic            expire_pulse
`ifdef PACKET_REASSEMBLER_STATS_EN
  ,
  output logic [STAT_W-1:0] drop_count,
  output logic [STAT_W-1:0] expire_count
`endif
);

  localparam int unsigned IDX_W = $clog2(NUM_SLOTS);

  packet_element_t      slots     [NUM_SLOTS];
  packet_element_t      slots_nxt [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] occupied, occupied_nxt;
  logic [NUM_SLOTS-1:0] free_vec, done_vec;
  logic [IDX_W-1:0]     free_idx, done_idx, hit_idx, head_idx, sel_q;
  logic                 free_found, done_found, hit_found;
  logic [TAIL_W-1:0]    next_tail;
  logic                 drop_nxt, expire_nxt;
  drop_reason_t         reason_nxt;

  assign free_vec = ~occupied;

  lowest_index_finder #(.WIDTH(NUM_SLOTS)) u_free_finder (
    .req     (free_vec),
    .idx_c   (free_idx),
    .found_c (free_found)
  );

  lowest_index_finder #(.WIDTH(NUM_SLOTS)) u_done_finder (
    .req     (done_vec),
    .idx_c   (done_idx),
    .found_c (done_found)
  );

  // Find the filling slot that already owns the incoming packet id.
  always_comb begin
    hit_found = 1'b0;
    hit_idx   = '0;
    for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
      if (occupied[i] && !slots[i].is_complete && slots[i].packet_id == in_packet_id) begin
        hit_found = 1'b1;
        hit_idx   = IDX_W'(i);
      end
    end
  end

  // Next slot state: ageing/expiry, handshake release, then the incoming flit (which wins over expiry).
  always_comb begin
    slots_nxt    = slots;
    occupied_nxt = occupied;
    drop_nxt     = 1'b0;
    reason_nxt   = DROP_NONE;
    expire_nxt   = 1'b0;
    head_idx     = hit_found ? hit_idx : free_idx;
    next_tail    = slots[hit_idx].tail_index + 1'b1;

    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (occupied[i] && !slots[i].is_complete && !(in_valid && hit_found && hit_idx == IDX_W'(i))) begin
        if (slots[i].timer == TIMER_W'(EXPIRE_TIME - 1)) begin
          occupied_nxt[i] = 1'b0;
          expire_nxt      = 1'b1;
        end else begin
          slots_nxt[i].timer = slots[i].timer + 1'b1;
        end
      end
    end

    if (out_valid && out_ready) begin
      occupied_nxt[sel_q] = 1'b0;
    end

    if (in_valid) begin
      if (in_is_head) begin
        if (hit_found || free_found) begin
          slots_nxt[head_idx]             = '0;
          slots_nxt[head_idx].packet_id   = in_packet_id;
          slots_nxt[head_idx].buffer[0]   = in_flit;
          slots_nxt[head_idx].is_complete = in_is_tail;
          occupied_nxt[head_idx]          = 1'b1;
        end else begin
          drop_nxt   = 1'b1;
          reason_nxt = DROP_NO_SLOT;
        end
      end else if (!hit_found) begin
        drop_nxt   = 1'b1;
        reason_nxt = DROP_NO_MATCH;
      end else if (slots[hit_idx].tail_index == TAIL_W'(MAX_NUM_OF_FLIT - 1)) begin
        occupied_nxt[hit_idx] = 1'b0;
        drop_nxt              = 1'b1;
        reason_nxt            = DROP_OVERFLOW;
      end else begin
        slots_nxt[hit_idx].buffer[next_tail] = in_flit;
        slots_nxt[hit_idx].tail_index        = next_tail;
        slots_nxt[hit_idx].timer             = '0;
        slots_nxt[hit_idx].is_complete       = in_is_tail;
      end
    end
  end

  // Complete slots as they will stand after this edge, so a completing flit shows up one cycle later.
  always_comb begin
    done_vec = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      done_vec[i] = occupied_nxt[i] && slots_nxt[i].is_complete;
    end
  end

  // Slot storage and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupied <= '0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        slots[i] <= '0;
      end
    end else begin
      occupied <= occupied_nxt;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        slots[i] <= slots_nxt[i];
      end
    end
  end

  // Output port and pulses; the presented slot stays locked until it is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_packet   <= '0;
      sel_q        <= '0;
      drop_pulse   <= 1'b0;
      drop_reason  <= DROP_NONE;
      expire_pulse <= 1'b0;
    end else begin
      drop_pulse   <= drop_nxt;
      drop_reason  <= reason_nxt;
      expire_pulse <= expire_nxt;
      if (!(out_valid && !out_ready)) begin
        out_valid  <= done_found;
        sel_q      <= done_idx;
        out_packet <= done_found ? slots_nxt[done_idx] : '0;
      end
    end
  end

`ifdef PACKET_REASSEMBLER_STATS_EN
  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count   <= '0;
      expire_count <= '0;
    end else begin
      if (drop_pulse && drop_count != '1) begin
        drop_count <= drop_count + 1'b1;
      end
      if (expire_pulse && expire_count != '1) begin
        expire_count <= expire_count + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_packet_reassembler.sv
// Randomised + directed bench for packet_reassembler with a slot-level reference model and
// a per-cycle expectation queue consumed by an independent monitor.
module tb_packet_reassembler;
  import packet_reassembler_pkg::*;

  localparam int unsigned NS = DEFAULT_NUM_SLOTS;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  flit_t           in_flit = '0;
  packet_id_t      in_packet_id = '0;
  logic            in_is_head = 1'b0;
  logic            in_is_tail = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  packet_element_t out_packet;
  logic            drop_pulse;
  drop_reason_t    drop_reason;
  logic            expire_pulse;
`ifdef PACKET_REASSEMBLER_STATS_EN
  logic [STAT_W-1:0] drop_count;
  logic [STAT_W-1:0] expire_count;
`endif

  packet_reassembler #(.NUM_SLOTS(NS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_flit      (in_flit),
    .in_packet_id (in_packet_id),
    .in_is_head   (in_is_head),
    .in_is_tail   (in_is_tail),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_packet   (out_packet),
    .drop_pulse   (drop_pulse),
    .drop_reason  (drop_reason),
    .expire_pulse (expire_pulse)
`ifdef PACKET_REASSEMBLER_STATS_EN
    ,
    .drop_count   (drop_count),
    .expire_count (expire_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            ov;
    packet_element_t pkt;
    logic            drop;
    drop_reason_t    rs;
    logic            ex;
`ifdef PACKET_REASSEMBLER_STATS_EN
    logic [15:0]     dc;
    logic [15:0]     ec;
`endif
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  bit   done = 1'b0;

  // Reference model: each slot is an id plus a queue of stored flits and an idle age.
  bit          m_occ  [NS];
  packet_id_t  m_id   [NS];
  flit_t       m_fl   [NS][$];
  int unsigned m_age  [NS];
  bit          m_done [NS];
  bit          m_ov;
  int          m_sel;
`ifdef PACKET_REASSEMBLER_STATS_EN
  int          m_dcnt, m_ecnt;
  bit          m_prev_drop, m_prev_exp;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_pkt(input string name, input packet_element_t act, input packet_element_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic packet_element_t model_pkt(input int s);
    packet_element_t p;
    p = '0;
    p.packet_id = m_id[s];
    for (int j = 0; j < m_fl[s].size(); j++) p.buffer[j] = m_fl[s][j];
    p.tail_index  = TAIL_W'(m_fl[s].size() - 1);
    p.timer       = '0;
    p.is_complete = 1'b1;
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_occ[i] = 1'b0;
      m_done[i] = 1'b0;
      m_age[i] = 0;
      m_fl[i].delete();
    end
    m_ov = 1'b0;
    m_sel = 0;
`ifdef PACKET_REASSEMBLER_STATS_EN
    m_dcnt = 0; m_ecnt = 0; m_prev_drop = 1'b0; m_prev_exp = 1'b0;
`endif
  endtask

  // Advance the model across one clock edge and queue what the DUT should show afterwards.
  task automatic model_step(input bit v, input packet_id_t id, input bit hd, input bit tl,
                            input flit_t f, input bit rdy);
    exp_t e;
    int hit = -1;
    int fr = -1;
    int t;
    e.drop = 1'b0;
    e.rs = DROP_NONE;
    e.ex = 1'b0;
    for (int i = 0; i < NS; i++) if (hit < 0 && m_occ[i] && !m_done[i] && m_id[i] == id) hit = i;
    for (int i = 0; i < NS; i++) if (fr < 0 && !m_occ[i]) fr = i;
    if (m_ov && rdy) m_occ[m_sel] = 1'b0;
    for (int i = 0; i < NS; i++) begin
      if (m_occ[i] && !m_done[i] && !(v && i == hit)) begin
        if (m_age[i] == EXPIRE_TIME - 1) begin
          m_occ[i] = 1'b0;
          e.ex = 1'b1;
        end else m_age[i]++;
      end
    end
    if (v) begin
      if (hd) begin
        t = (hit >= 0) ? hit : fr;
        if (t < 0) begin
          e.drop = 1'b1; e.rs = DROP_NO_SLOT;
        end else begin
          m_occ[t] = 1'b1; m_id[t] = id; m_fl[t].delete(); m_fl[t].push_back(f);
          m_age[t] = 0; m_done[t] = tl;
        end
      end else if (hit < 0) begin
        e.drop = 1'b1; e.rs = DROP_NO_MATCH;
      end else if (m_fl[hit].size() == MAX_NUM_OF_FLIT) begin
        m_occ[hit] = 1'b0;
        e.drop = 1'b1; e.rs = DROP_OVERFLOW;
      end else begin
        m_fl[hit].push_back(f); m_age[hit] = 0; m_done[hit] = tl;
      end
    end
    if (!(m_ov && !rdy)) begin
      m_ov = 1'b0;
      for (int i = 0; i < NS; i++) begin
        if (!m_ov && m_occ[i] && m_done[i]) begin
          m_ov = 1'b1; m_sel = i;
        end
      end
    end
    e.ov = m_ov;
    e.pkt = m_ov ? model_pkt(m_sel) : '0;
`ifdef PACKET_REASSEMBLER_STATS_EN
    if (m_prev_drop && m_dcnt < 65535) m_dcnt++;
    if (m_prev_exp && m_ecnt < 65535) m_ecnt++;
    m_prev_drop = e.drop;
    m_prev_exp = e.ex;
    e.dc = 16'(m_dcnt);
    e.ec = 16'(m_ecnt);
`endif
    exp_q.push_back(e);
  endtask

  task automatic apply(input bit v, input packet_id_t id, input bit hd, input bit tl, input bit rdy);
    flit_t f;
    f = flit_t'($urandom);
    in_valid = v; in_packet_id = id; in_is_head = hd; in_is_tail = tl; in_flit = f; out_ready = rdy;
    model_step(v, id, hd, tl, f, rdy);
  endtask

  task automatic drive(input bit v, input int id, input bit hd, input bit tl, input bit rdy);
    @(negedge clk);
    #1;
    apply(v, packet_id_t'(id), hd, tl, rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) drive(1'b0, 0, 1'b0, 1'b0, rdy);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    in_valid = 1'b0; in_is_head = 1'b0; in_is_tail = 1'b0; out_ready = 1'b0;
    model_reset();
    exp_q.delete();
    repeat (n) @(negedge clk);
    #1;
    rst_n = 1'b1;
    apply(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: checks reset values while in reset, otherwise consumes one expectation per cycle.
  always @(negedge clk) begin
    if (!done) begin
      if (!rst_n) begin
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_drop_pulse", 32'(drop_pulse), 32'd0);
        chk("rst_expire_pulse", 32'(expire_pulse), 32'd0);
        chk("rst_drop_reason", 32'(drop_reason), 32'(DROP_NONE));
        chk_pkt("rst_out_packet", out_packet, '0);
`ifdef PACKET_REASSEMBLER_STATS_EN
        chk("rst_drop_count", 32'(drop_count), 32'd0);
        chk("rst_expire_count", 32'(expire_count), 32'd0);
`endif
      end else if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: got no expectation required one at %0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_valid", 32'(out_valid), 32'(mon_e.ov));
        if (mon_e.ov) chk_pkt("out_packet", out_packet, mon_e.pkt);
        chk("drop_pulse", 32'(drop_pulse), 32'(mon_e.drop));
        chk("drop_reason", 32'(drop_reason), 32'(mon_e.rs));
        chk("expire_pulse", 32'(expire_pulse), 32'(mon_e.ex));
`ifdef PACKET_REASSEMBLER_STATS_EN
        chk("drop_count", 32'(drop_count), 32'(mon_e.dc));
        chk("expire_count", 32'(expire_count), 32'(mon_e.ec));
`endif
      end
    end
  end

  initial begin
    model_reset();
    do_reset(2);

    // Four-flit packet id 5, then immediate reuse with a single-flit packet.
    drive(1, 5, 1, 0, 1); drive(1, 5, 0, 0, 1); drive(1, 5, 0, 0, 1); drive(1, 5, 0, 1, 1);
    drive(1, 6, 1, 1, 1);
    idle(3, 1);

    // Interleaved ids 1 and 2 held back, then drained.
    drive(1, 1, 1, 0, 0); drive(1, 2, 1, 0, 0); drive(1, 1, 0, 0, 0); drive(1, 2, 0, 0, 0);
    drive(1, 1, 0, 1, 0); drive(1, 2, 0, 1, 0);
    idle(3, 0); idle(5, 1);

    // Head then silence: expiry, then a late body has no match.
    drive(1, 3, 1, 0, 1);
    idle(EXPIRE_TIME + 5, 1);
    drive(1, 3, 0, 0, 1);
    idle(2, 1);

    // Slot exhaustion, then overflow on a nine-flit packet; remainder expires.
    for (int k = 0; k < 5; k++) drive(1, 10 + k, 1, 0, 1);
    for (int k = 0; k < 8; k++) drive(1, 10, 0, 0, 1);
    idle(EXPIRE_TIME + 5, 1);

    // Restarted head and an exact eight-flit packet.
    drive(1, 30, 1, 0, 1); drive(1, 30, 0, 0, 1); drive(1, 30, 1, 0, 1);
    for (int k = 0; k < 6; k++) drive(1, 30, 0, 0, 1);
    drive(1, 30, 0, 1, 1);
    drive(1, 30, 0, 0, 1);
    idle(3, 1);

    // Two completes under ten cycles of backpressure.
    drive(1, 20, 1, 1, 0); drive(1, 21, 1, 1, 0);
    idle(10, 0); idle(4, 1);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 9) < 6, $urandom_range(0, 5), $urandom_range(0, 9) < 3,
            $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 7);
    end
    idle(EXPIRE_TIME + 5, 1);

    // Reset in the middle of packets.
    drive(1, 7, 1, 0, 0); drive(1, 7, 0, 0, 0); drive(1, 8, 1, 1, 0); idle(2, 0);
    do_reset(3);
    idle(3, 1);
    drive(1, 7, 0, 0, 1);
    idle(2, 1);

`ifdef PACKET_REASSEMBLER_STATS_EN
    // Drive counters into saturation with unmatched bodies.
    repeat (65540) drive(1, 99, 0, 0, 1);
    idle(3, 1);
`endif

    @(negedge clk);
    #1;
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
